// File: rtl/lock_if.sv
// Keypad lock pin bundle: code switches and buttons in, lock status out.
interface lock_if #(
    parameter int unsigned PW_WIDTH = 7
);
    logic [PW_WIDTH-1:0] code_in;
    logic                set_btn;
    logic                enter_btn;
    logic [2:0]          state_o;
    logic                open_o;
    logic                alarm_o;
    logic                blink_o;
    logic [1:0]          fail_cnt_o;

    modport master (
        output code_in, set_btn, enter_btn,
        input  state_o, open_o, alarm_o, blink_o, fail_cnt_o
    );

    modport slave (
        input  code_in, set_btn, enter_btn,
        output state_o, open_o, alarm_o, blink_o, fail_cnt_o
    );
endinterface

// File: rtl/lock_sequencer.sv
// Keypad lock controller: button synchronizers, lock FSM, password store,
// failed-attempt counter and the shared open/entry/alarm window timer.
module lock_sequencer #(
    parameter int unsigned PW_WIDTH     = 7,
    parameter int unsigned MAX_TRIES    = 3,
    parameter logic [15:0] OPEN_CYCLES  = 16'd50000,
    parameter logic [15:0] ENTRY_CYCLES = 16'd50000,
    parameter logic [15:0] ALARM_CYCLES = 16'd50000,
    parameter logic [15:0] BLINK_HALF   = 16'd100
) (
    input  logic  clk,
    input  logic  rst_n,
    lock_if.slave bus
);

    localparam int unsigned TIMER_W = 16;
    localparam int unsigned FAIL_W  = 2;
    localparam int unsigned SYNC_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_SET   = 3'b001,
        ST_OPEN  = 3'b010,
        ST_ALARM = 3'b011,
        ST_INPUT = 3'b100
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [TIMER_W-1:0]   bcnt_q, bcnt_d;
    logic [PW_WIDTH-1:0]  pw_q, pw_d;
    logic [FAIL_W-1:0]    fail_q, fail_d;
    logic                 blink_q, blink_d;
    logic                 open_q, open_d;
    logic                 alarm_q, alarm_d;
    logic [SYNC_W-1:0]    enter_sync, set_sync;

    logic                 enter_p_c;
    logic                 set_p_c;
    logic                 expired_c;
    logic [FAIL_W-1:0]    fail_inc_c;

    // Two-flop synchronizers plus an edge-detect flop per button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enter_sync <= '0;
            set_sync   <= '0;
        end else begin
            enter_sync <= {enter_sync[SYNC_W-2:0], bus.enter_btn};
            set_sync   <= {set_sync[SYNC_W-2:0], bus.set_btn};
        end
    end

    // Enter has priority: a set pulse in the same cycle is dropped.
    assign enter_p_c  = enter_sync[1] & ~enter_sync[2];
    assign set_p_c    = set_sync[1] & ~set_sync[2] & ~enter_p_c;
    assign expired_c  = (timer_q == '0);
    assign fail_inc_c = fail_q + FAIL_W'(1);

    // State, timers, password and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            bcnt_q  <= '0;
            pw_q    <= '0;
            fail_q  <= '0;
            blink_q <= 1'b0;
            open_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bcnt_q  <= bcnt_d;
            pw_q    <= pw_d;
            fail_q  <= fail_d;
            blink_q <= blink_d;
            open_q  <= open_d;
            alarm_q <= alarm_d;
        end
    end

    // Next-state, timer reloads, password/fail updates and blink generation.
    always_comb begin
        state_d = state_q;
        timer_d = expired_c ? '0 : timer_q - TIMER_W'(1);
        pw_d    = pw_q;
        fail_d  = fail_q;
        blink_d = 1'b0;
        bcnt_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (enter_p_c) begin
                    state_d = ST_INPUT;
                    timer_d = ENTRY_CYCLES - TIMER_W'(1);
                end
            end
            ST_INPUT: begin
                if (enter_p_c) begin
                    if (bus.code_in == pw_q) begin
                        state_d = ST_OPEN;
                        timer_d = OPEN_CYCLES - TIMER_W'(1);
                        fail_d  = '0;
                    end else begin
                        fail_d = fail_inc_c;
                        if (fail_inc_c == FAIL_W'(MAX_TRIES)) begin
                            state_d = ST_ALARM;
                            timer_d = ALARM_CYCLES - TIMER_W'(1);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else if (expired_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (enter_p_c) begin
                    state_d = ST_IDLE;
                end else if (set_p_c) begin
                    state_d = ST_SET;
                end else if (expired_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SET: begin
                if (set_p_c) begin
                    pw_d    = bus.code_in;
                    state_d = ST_IDLE;
                end else if (enter_p_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ALARM: begin
                if (expired_c) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_ALARM) begin
            if (state_q != ST_ALARM) begin
                blink_d = 1'b1;
                bcnt_d  = BLINK_HALF - TIMER_W'(1);
            end else if (bcnt_q == '0) begin
                blink_d = ~blink_q;
                bcnt_d  = BLINK_HALF - TIMER_W'(1);
            end else begin
                blink_d = blink_q;
                bcnt_d  = bcnt_q - TIMER_W'(1);
            end
        end

        open_d  = (state_d == ST_OPEN);
        alarm_d = (state_d == ST_ALARM);
    end

    assign bus.state_o    = state_q;
    assign bus.open_o     = open_q;
    assign bus.alarm_o    = alarm_q;
    assign bus.blink_o    = blink_q;
    assign bus.fail_cnt_o = fail_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: scripted scenarios and random presses compared
// cycle by cycle against a behavioural model of the lock.
module tb_lock_sequencer;

    localparam int OPEN_N  = 20;
    localparam int ENTRY_N = 30;
    localparam int ALARM_N = 16;
    localparam int BLINK_N = 4;
    localparam int TRIES   = 3;

    localparam logic [2:0] M_IDLE  = 3'd0;
    localparam logic [2:0] M_INPUT = 3'd1;
    localparam logic [2:0] M_OPEN  = 3'd2;
    localparam logic [2:0] M_SET   = 3'd3;
    localparam logic [2:0] M_ALARM = 3'd4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lock_if #(.PW_WIDTH(7)) bus ();

    lock_sequencer #(
        .PW_WIDTH    (7),
        .MAX_TRIES   (3),
        .OPEN_CYCLES (16'd20),
        .ENTRY_CYCLES(16'd30),
        .ALARM_CYCLES(16'd16),
        .BLINK_HALF  (16'd4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Model: age = cycles spent in the current mode; eh/sh = last three button samples.
    typedef struct packed {
        logic [2:0]  mode;
        logic [15:0] age;
        logic [6:0]  pw;
        logic [1:0]  fails;
        logic [2:0]  eh;
        logic [2:0]  sh;
    } model_t;

    function automatic model_t model_next(input model_t m, input logic e_in,
                                          input logic s_in, input logic [6:0] code);
        model_t n;
        logic   ep, sp;
        int     f;
        n    = m;
        ep   = m.eh[1] & ~m.eh[2];
        sp   = m.sh[1] & ~m.sh[2] & ~ep;
        n.eh = {m.eh[1:0], e_in};
        n.sh = {m.sh[1:0], s_in};
        n.age = m.age + 16'd1;
        case (m.mode)
            M_IDLE:  if (ep) begin n.mode = M_INPUT; n.age = '0; end
            M_INPUT: begin
                if (ep) begin
                    n.age = '0;
                    if (code == m.pw) begin
                        n.mode = M_OPEN; n.fails = '0;
                    end else begin
                        f = int'(m.fails) + 1;
                        n.fails = 2'(f);
                        n.mode  = (f == TRIES) ? M_ALARM : M_IDLE;
                    end
                end else if (int'(m.age) == ENTRY_N - 1) begin
                    n.mode = M_IDLE; n.age = '0;
                end
            end
            M_OPEN: begin
                if (ep)                               begin n.mode = M_IDLE; n.age = '0; end
                else if (sp)                          begin n.mode = M_SET;  n.age = '0; end
                else if (int'(m.age) == OPEN_N - 1)   begin n.mode = M_IDLE; n.age = '0; end
            end
            M_SET: begin
                if (sp)      begin n.pw = code; n.mode = M_IDLE; n.age = '0; end
                else if (ep) begin n.mode = M_IDLE; n.age = '0; end
            end
            M_ALARM: begin
                if (int'(m.age) == ALARM_N - 1) begin
                    n.mode = M_IDLE; n.age = '0; n.fails = '0;
                end
            end
            default: n.mode = M_IDLE;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] exp_of(input model_t m);
        logic [2:0] st;
        logic       bl;
        case (m.mode)
            M_INPUT: st = 3'b100;
            M_OPEN:  st = 3'b010;
            M_SET:   st = 3'b001;
            M_ALARM: st = 3'b011;
            default: st = 3'b000;
        endcase
        bl = (m.mode == M_ALARM) && (((int'(m.age) / BLINK_N) % 2) == 0);
        return {st, m.mode == M_OPEN, m.mode == M_ALARM, bl, m.fails};
    endfunction

    model_t     m;
    logic [7:0] obs, expv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_next(m, bus.enter_btn, bus.set_btn, bus.code_in);
    end

    assign obs  = {bus.state_o, bus.open_o, bus.alarm_o, bus.blink_o, bus.fail_cnt_o};
    assign expv = exp_of(m);

    function automatic bit is_held(input int q[$], input int c);
        foreach (q[i]) if (c >= q[i] && c < q[i] + 3) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input logic e, input logic s, input logic [6:0] code);
        bus.enter_btn = e;
        bus.set_btn   = s;
        bus.code_in   = code;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 7'h00);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs !== 8'h00) begin n_fail++; $display("FAIL reset_async got=%b exp=%b", obs, 8'h00); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (obs !== 8'h00) begin n_fail++; $display("FAIL reset_release got=%b exp=%b", obs, 8'h00); end
        n_chk++;
        if (obs !== expv) begin n_fail++; $display("FAIL reset_model got=%b exp=%b", obs, expv); end
    endtask

    task automatic test_open();
        int eq[$] = '{0, 8};
        int ocnt = 0;
        for (int c = 0; c < 60; c++) begin
            drive(is_held(eq, c), 1'b0, 7'h00);
            @(negedge clk);
            n_chk++;
            if (obs !== expv) begin n_fail++; $display("FAIL open c=%0d got=%b exp=%b", c, obs, expv); end
            if (c == 12) begin
                n_chk++;
                if (bus.state_o !== 3'b010) begin n_fail++; $display("FAIL open_state got=%b exp=010", bus.state_o); end
            end
            if (bus.open_o) ocnt++;
        end
        n_chk++;
        if (ocnt != OPEN_N) begin n_fail++; $display("FAIL open_len got=%0d exp=%0d", ocnt, OPEN_N); end
    endtask

    task automatic test_set_password();
        int eq[$] = '{0, 8, 28, 36, 44, 52, 60};
        int sq[$] = '{14, 20};
        for (int c = 0; c < 70; c++) begin
            drive(is_held(eq, c), is_held(sq, c), (c >= 12 && c < 50) ? 7'h5A : 7'h00);
            @(negedge clk);
            n_chk++;
            if (obs !== expv) begin n_fail++; $display("FAIL setpw c=%0d got=%b exp=%b", c, obs, expv); end
            if (c == 42) begin
                n_chk++;
                if (bus.state_o !== 3'b010) begin n_fail++; $display("FAIL setpw_open got=%b exp=010", bus.state_o); end
            end
        end
        n_chk++;
        if (obs !== 8'b000_0_0_0_01) begin n_fail++; $display("FAIL setpw_wrong got=%b exp=%b", obs, 8'b00000001); end
    endtask

    task automatic test_alarm();
        int         eq[$] = '{0, 8, 16, 24, 32, 40, 46};
        int         sq[$] = '{50};
        int         acnt  = 0;
        logic [15:0] pat  = '0;
        drive(1'b0, 1'b0, 7'h11);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 75; c++) begin
            drive(is_held(eq, c), is_held(sq, c), 7'h11);
            @(negedge clk);
            n_chk++;
            if (obs !== expv) begin n_fail++; $display("FAIL alarm c=%0d got=%b exp=%b", c, obs, expv); end
            if (bus.alarm_o) begin
                acnt++;
                pat = {pat[14:0], bus.blink_o};
            end
        end
        n_chk++;
        if (acnt != ALARM_N) begin n_fail++; $display("FAIL alarm_len got=%0d exp=%0d", acnt, ALARM_N); end
        n_chk++;
        if (pat !== 16'b1111000011110000) begin n_fail++; $display("FAIL blink_pat got=%b exp=%b", pat, 16'b1111000011110000); end
        n_chk++;
        if (obs !== 8'h00) begin n_fail++; $display("FAIL alarm_exit got=%b exp=%b", obs, 8'h00); end
    endtask

    task automatic test_timeout();
        int eq[$] = '{0, 8, 16, 56, 64, 72, 80};
        for (int c = 0; c < 110; c++) begin
            drive(is_held(eq, c), 1'b0, ((c >= 4 && c < 14) || (c >= 60 && c < 70)) ? 7'h11 : 7'h00);
            @(negedge clk);
            n_chk++;
            if (obs !== expv) begin n_fail++; $display("FAIL timeout c=%0d got=%b exp=%b", c, obs, expv); end
            if (c == 45) begin
                n_chk++;
                if (obs !== 8'b100_0_0_0_01) begin n_fail++; $display("FAIL entry_wait got=%b exp=%b", obs, 8'b10000001); end
            end
            if (c == 55) begin
                n_chk++;
                if (obs !== 8'b000_0_0_0_01) begin n_fail++; $display("FAIL entry_expire got=%b exp=%b", obs, 8'b00000001); end
            end
            if (c == 86) begin
                n_chk++;
                if (obs !== 8'b010_1_0_0_00) begin n_fail++; $display("FAIL retry_open got=%b exp=%b", obs, 8'b01010000); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int eq[$]  = '{0, 8, 14};
        int sq[$]  = '{14};
        int n_in   = 0;
        logic [2:0] prev = 3'b000;
        for (int c = 0; c < 100; c++) begin
            drive(is_held(eq, c) || (c >= 30 && c < 80), is_held(sq, c), 7'h00);
            @(negedge clk);
            n_chk++;
            if (obs !== expv) begin n_fail++; $display("FAIL b2b c=%0d got=%b exp=%b", c, obs, expv); end
            if (c == 18) begin
                n_chk++;
                if (bus.state_o !== 3'b000) begin n_fail++; $display("FAIL both_btn got=%b exp=000", bus.state_o); end
            end
            if (c >= 25 && prev != 3'b100 && bus.state_o == 3'b100) n_in++;
            prev = bus.state_o;
        end
        n_chk++;
        if (n_in != 1) begin n_fail++; $display("FAIL hold_enter got=%0d exp=1", n_in); end
    endtask

    task automatic test_reset_midop();
        int eq[$] = '{0, 8, 28, 36, 52, 60, 68, 76, 84, 92, 106, 114};
        int sq[$] = '{14, 20, 42};
        logic [6:0] code;
        for (int c = 0; c < 125; c++) begin
            if (c >= 18 && c < 40)      code = 7'h5A;
            else if (c >= 50 && c < 95) code = 7'h11;
            else                        code = 7'h00;
            drive(is_held(eq, c), is_held(sq, c), code);
            @(negedge clk);
            n_chk++;
            if (obs !== expv) begin n_fail++; $display("FAIL midop c=%0d got=%b exp=%b", c, obs, expv); end
            if (c == 48 || c == 100) begin
                n_chk++;
                if (bus.state_o !== ((c == 48) ? 3'b001 : 3'b011)) begin
                    n_fail++; $display("FAIL pre_reset c=%0d got=%b", c, bus.state_o);
                end
                #1 rst_n = 1'b0;
                #1;
                n_chk++;
                if (obs !== 8'h00) begin n_fail++; $display("FAIL midop_async c=%0d got=%b exp=%b", c, obs, 8'h00); end
                @(negedge clk);
                rst_n = 1'b1;
            end
            if (c == 120) begin
                n_chk++;
                if (bus.state_o !== 3'b010) begin n_fail++; $display("FAIL pw_cleared got=%b exp=010", bus.state_o); end
            end
        end
    endtask

    task automatic test_random();
        int hold = 0;
        int gap  = 4;
        int r;
        drive(1'b0, 1'b0, 7'h00);
        for (int c = 0; c < 3000; c++) begin
            if (hold > 0) begin
                hold--;
                if (hold == 0) begin
                    bus.enter_btn = 1'b0;
                    bus.set_btn   = 1'b0;
                    gap = $urandom_range(2, 40);
                end
            end else if (gap > 0) begin
                gap--;
            end else begin
                r = $urandom_range(0, 7);
                bus.enter_btn = (r < 5);
                bus.set_btn   = (r >= 3);
                bus.code_in   = ($urandom_range(0, 1) == 1) ? m.pw : 7'($urandom);
                hold = $urandom_range(1, 6);
            end
            @(negedge clk);
            n_chk++;
            if (obs !== expv) begin n_fail++; $display("FAIL random c=%0d got=%b exp=%b", c, obs, expv); end
        end
    endtask

    initial begin
        test_reset();
        test_open();
        test_set_password();
        test_alarm();
        test_timeout();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Clocked controller for the keypad lock: synchronizes the two push-buttons, sequences the IDLE / INPUT_PASSWORD / OPENED / SET_AWAITING / ALARM state machine, stores and compares the 7-bit password, counts failed attempts and times the open, entry and alarm windows. It sits between the top-level pins (`ui_in` code switches, `ui_in[0]` set button, `uio_in[0]` enter button) and the status outputs on `uo_out`, and replaces per-button edge-triggered process logic with one synchronous FSM.

## Interface
- `PW_WIDTH`, 7: password / code width.
- `MAX_TRIES`, 3: consecutive wrong codes that trigger ALARM (1..3).
- `OPEN_CYCLES`, 16'd50000: cycles spent in OPENED before auto-relock.
- `ENTRY_CYCLES`, 16'd50000: cycles allowed in INPUT_PASSWORD before abandoning.
- `ALARM_CYCLES`, 16'd50000: cycles spent in ALARM.
- `BLINK_HALF`, 16'd100: half-period of alarm blink, in cycles.

- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `code_in` in PW_WIDTH: code switches, static while a button is pressed.
- `set_btn` in 1: set button, asynchronous, active-high.
- `enter_btn` in 1: enter button, asynchronous, active-high.
- `state_o` out 3: current state (IDLE=000, SET_AWAITING=001, OPENED=010, ALARM=011, INPUT_PASSWORD=100).
- `open_o` out 1: 1 iff state is OPENED.
- `alarm_o` out 1: 1 iff state is ALARM.
- `blink_o` out 1: alarm blink output.
- `fail_cnt_o` out 2: consecutive wrong attempts.

## Operation
- Each button: 2-flop synchronizer plus a third flop; press pulse = sync2 & ~sync3 (one cycle per rising edge). Held buttons produce a single pulse.
- If both pulses occur in the same cycle, enter wins; set is dropped.
- Password register resets to 0; fail count resets to 0.
- IDLE: enter -> INPUT_PASSWORD (timer loaded). set ignored.
- INPUT_PASSWORD: enter with code_in == password -> OPENED, fail count cleared. Enter with mismatch -> fail count +1; if the new count == MAX_TRIES -> ALARM, otherwise -> IDLE. Timer expiry without enter -> IDLE, fail count unchanged. set ignored.
- OPENED: set -> SET_AWAITING; enter -> IDLE; timer expiry -> IDLE.
- SET_AWAITING: set -> password <= code_in, -> IDLE. enter -> IDLE, password unchanged. No timeout.
- ALARM: all button pulses ignored; on timer expiry -> IDLE, fail count cleared.
- One shared 16-bit down-timer: loaded with N-1 on entry to a timed state (N = OPEN/ENTRY/ALARM_CYCLES); decrements each cycle; expiry when 0 and the state is timed. The state is therefore held for exactly N cycles.
- Blink: separate 16-bit counter active only in ALARM. blink_o = 1 on the first ALARM cycle and toggles every BLINK_HALF cycles; it is 0 in every other state.
- Unused encodings 101–111 -> IDLE on the next edge.

## Timing
- Reset (asynchronous assert, registered release): state_o=000, open_o=0, alarm_o=0, blink_o=0, fail_cnt_o=0, password=0, timers=0, synchronizer flops=0.
- Button latency: input high before rising edge E1 -> pulse during the cycle after E2 -> state_o updated at E3. Total 3 edges.
- open_o, alarm_o and blink_o are registered or decoded from registered state; they change on the same edge as state_o.
- code_in is sampled on the edge that consumes the pulse (E3); it is not synchronized and must be stable for at least 3 cycles around the press.
- Reset mid-operation (e.g. in ALARM or SET_AWAITING) returns to IDLE immediately and clears the stored password.

## Test plan
Use OPEN=20, ENTRY=30, ALARM=16, BLINK_HALF=4 and MAX_TRIES=3 for all scenarios.
- Reset, code_in=0, press enter twice: state goes IDLE -> INPUT_PASSWORD -> OPENED (010). open_o=1 for exactly 20 cycles, then IDLE.
- From OPENED: press set, set code_in=7'h5A, press set -> IDLE. Then enter with 7'h5A -> OPENED. Enter with 7'h00 -> IDLE and fail_cnt_o=1.
- Three wrong codes -> ALARM (011). alarm_o=1 for 16 cycles; blink_o pattern 1111000011110000; presses are ignored; then IDLE with fail_cnt_o=0.
- Enter followed by no further input for 30 cycles -> IDLE; fail_cnt_o unchanged. A wrong code then a right code -> OPENED with fail_cnt_o=0.
- set and enter rise in the same cycle while OPENED -> IDLE, not SET_AWAITING. Holding enter high for 50 cycles produces only one transition.
- Assert rst_n low during ALARM and during SET_AWAITING -> all outputs 0 asynchronously; afterwards password 0 opens the lock.
